// File: rtl/fifo_ambition_pkg.sv
// Shared definitions for the single-clock prefetch FIFO: default sizing,
// flag levels and constant helpers used when elaborating the FIFO.
package fifo_ambition_pkg;

    localparam int DEF_DEPTH_WIDTH = 10;
    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_AE_LEVEL    = 4;
    localparam int DEF_AF_MARGIN   = 4;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    function automatic int cap_of(input int depth_width);
        return 1 << depth_width;
    endfunction

endpackage

// File: rtl/fifo_ambition_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered
// output. The array carries no reset; only written locations are ever read.
module fifo_ambition_sdp_ram
    import fifo_ambition_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_DEPTH_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fifo_ambition_sync_prefetch.sv
// Single-clock first-word-fall-through FIFO: RAM store plus a two-entry
// head/skid prefetch buffer, occupancy count, level flags and sticky errors.
module fifo_ambition_sync_prefetch
    import fifo_ambition_pkg::*;
#(
    parameter int DEPTH_WIDTH = DEF_DEPTH_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int AF_LEVEL    = cap_of(DEPTH_WIDTH) - DEF_AF_MARGIN,
    parameter int AE_LEVEL    = DEF_AE_LEVEL
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_flush,
    input  logic                   i_wr_en,
    output logic                   o_wr_vld,
    input  logic [DATA_WIDTH-1:0]  i_wr_data,
    input  logic                   i_rd_en,
    output logic                   o_rd_vld,
    output logic [DATA_WIDTH-1:0]  o_rd_data,
    output logic [DEPTH_WIDTH:0]   o_count,
    output logic                   o_almost_full,
    output logic                   o_almost_empty,
    output logic                   o_overflow,
    output logic                   o_underflow
);

    localparam int CAP   = cap_of(DEPTH_WIDTH);
    localparam int CNT_W = clog2(CAP + 1);

    logic [DEPTH_WIDTH-1:0] r_wr_ptr;
    logic [DEPTH_WIDTH-1:0] r_rd_ptr;
    logic [CNT_W-1:0]       r_ram_cnt;
    logic [CNT_W-1:0]       r_count;
    logic                   r_wr_vld;
    logic                   r_almost_full;
    logic                   r_almost_empty;
    logic                   r_overflow;
    logic                   r_underflow;

    logic                   r_head_vld;
    logic                   r_skid_vld;
    logic                   r_inflight;
    logic [DATA_WIDTH-1:0]  r_head_data;
    logic [DATA_WIDTH-1:0]  r_skid_data;

    logic                   w_wr_acc;
    logic                   w_pop;
    logic [1:0]             w_occ_after;
    logic                   w_rd_issue;
    logic [CNT_W-1:0]       w_count_next;
    logic [DATA_WIDTH-1:0]  w_ram_q;

    assign w_wr_acc = i_wr_en & r_wr_vld & ~i_flush;
    assign w_pop    = i_rd_en & r_head_vld & ~i_flush;

    // Prefetch slots still taken after this edge, including the read already in flight.
    assign w_occ_after = {1'b0, r_head_vld} + {1'b0, r_skid_vld}
                       + {1'b0, r_inflight} - {1'b0, w_pop};
    assign w_rd_issue  = (r_ram_cnt != '0) && (w_occ_after < 2'd2) && !i_flush;

    assign w_count_next = i_flush ? '0
                        : r_count + CNT_W'(w_wr_acc) - CNT_W'(w_pop);

    fifo_ambition_sdp_ram #(
        .ADDR_WIDTH (DEPTH_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .i_clk     (i_clk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (i_wr_data),
        .i_rd_en   (w_rd_issue),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_ram_q)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_ram_cnt      <= '0;
            r_count        <= '0;
            r_wr_vld       <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (i_flush) begin
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_ram_cnt <= '0;
            end else begin
                if (w_wr_acc) begin
                    r_wr_ptr <= r_wr_ptr + DEPTH_WIDTH'(1);
                end
                if (w_rd_issue) begin
                    r_rd_ptr <= r_rd_ptr + DEPTH_WIDTH'(1);
                end
                r_ram_cnt <= r_ram_cnt + CNT_W'(w_wr_acc) - CNT_W'(w_rd_issue);
            end
            r_count        <= w_count_next;
            r_wr_vld       <= (w_count_next != CNT_W'(CAP));
            r_almost_full  <= (int'(w_count_next) >= AF_LEVEL);
            r_almost_empty <= (int'(w_count_next) <= AE_LEVEL);
            r_overflow     <= i_flush ? 1'b0 : (r_overflow  | (i_wr_en & ~r_wr_vld));
            r_underflow    <= i_flush ? 1'b0 : (r_underflow | (i_rd_en & ~r_head_vld));
        end
    end

    // The head always holds the oldest word; a landing RAM word goes to the head
    // if it is (or is about to be) empty, otherwise it parks in the skid slot.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head_vld  <= 1'b0;
            r_skid_vld  <= 1'b0;
            r_inflight  <= 1'b0;
            r_head_data <= '0;
            r_skid_data <= '0;
        end else if (i_flush) begin
            r_head_vld <= 1'b0;
            r_skid_vld <= 1'b0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd_issue;
            if (w_pop) begin
                if (r_skid_vld) begin
                    r_head_data <= r_skid_data;
                    r_head_vld  <= 1'b1;
                    r_skid_vld  <= r_inflight;
                    if (r_inflight) begin
                        r_skid_data <= w_ram_q;
                    end
                end else begin
                    r_head_vld <= r_inflight;
                    if (r_inflight) begin
                        r_head_data <= w_ram_q;
                    end
                end
            end else if (!r_head_vld) begin
                r_head_vld <= r_inflight;
                if (r_inflight) begin
                    r_head_data <= w_ram_q;
                end
            end else if (r_inflight) begin
                r_skid_vld  <= 1'b1;
                r_skid_data <= w_ram_q;
            end
        end
    end

    assign o_wr_vld       = r_wr_vld;
    assign o_rd_vld       = r_head_vld;
    assign o_rd_data      = r_head_data;
    assign o_count        = r_count;
    assign o_almost_full  = r_almost_full;
    assign o_almost_empty = r_almost_empty;
    assign o_overflow     = r_overflow;
    assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_ambition_sync_prefetch.sv
// Scoreboard bench for the prefetch FIFO: a word queue plus a count/flag
// model, driven one cycle at a time.
module tb_fifo_ambition_sync_prefetch;

    localparam int DW  = 10;
    localparam int DAW = 16;
    localparam int CAP = 1 << DW;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            wr_en;
    logic            wr_vld;
    logic [DAW-1:0]  wr_data;
    logic            rd_en;
    logic            rd_vld;
    logic [DAW-1:0]  rd_data;
    logic [DW:0]     count;
    logic            almost_full;
    logic            almost_empty;
    logic            overflow;
    logic            underflow;

    int              total;
    int              bad;
    logic [DAW-1:0]  expq[$];
    int              mdl_count;
    logic            mdl_ovf;
    logic            mdl_unf;
    int              seq;

    fifo_ambition_sync_prefetch #(
        .DEPTH_WIDTH (DW),
        .DATA_WIDTH  (DAW)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_flush        (flush),
        .i_wr_en        (wr_en),
        .o_wr_vld       (wr_vld),
        .i_wr_data      (wr_data),
        .i_rd_en        (rd_en),
        .o_rd_vld       (rd_vld),
        .o_rd_data      (rd_data),
        .o_count        (count),
        .o_almost_full  (almost_full),
        .o_almost_empty (almost_empty),
        .o_overflow     (overflow),
        .o_underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkState();
        checkOutput("count", 32'(count), 32'(mdl_count));
        checkOutput("wr_vld", 32'(wr_vld), 32'(mdl_count != CAP));
        checkOutput("almost_full", 32'(almost_full), 32'(mdl_count >= CAP - 4));
        checkOutput("almost_empty", 32'(almost_empty), 32'(mdl_count <= 4));
        checkOutput("overflow", 32'(overflow), 32'(mdl_ovf));
        checkOutput("underflow", 32'(underflow), 32'(mdl_unf));
    endtask

    // One clock cycle: drive inputs, score pops against the queue, update the model.
    task automatic applyStimulus(input logic wr, input logic [DAW-1:0] d, input logic rd, input logic fl);
        wr_en   = wr;
        wr_data = d;
        rd_en   = rd;
        flush   = fl;
        if (fl) begin
            expq.delete();
            mdl_count = 0;
            mdl_ovf   = 1'b0;
            mdl_unf   = 1'b0;
        end else begin
            if (wr && mdl_count == CAP) mdl_ovf = 1'b1;
            if (rd && !rd_vld) mdl_unf = 1'b1;
            if (rd && rd_vld) begin
                if (expq.size() == 0) begin
                    checkOutput("pop_unexpected", 32'(rd_vld), 32'd0);
                end else begin
                    checkOutput("rd_data", 32'(rd_data), 32'(expq.pop_front()));
                end
                mdl_count--;
            end
            if (wr && (mdl_count + ((rd && rd_vld) ? 1 : 0)) != CAP) begin
                expq.push_back(d);
                mdl_count++;
            end
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        flush = 1'b0;
        checkState();
    endtask

    task automatic modelReset();
        expq.delete();
        mdl_count = 0;
        mdl_ovf   = 1'b0;
        mdl_unf   = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        seq = 0;
        rst = 1'b1;
        flush = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wr_data = '0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkState();
        checkOutput("reset_rd_vld", 32'(rd_vld), 32'd0);
        checkOutput("reset_rd_data", 32'(rd_data), 32'd0);

        // 1: single word fall-through latency
        $display("[TB] single word latency");
        applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0);
        checkOutput("lat_n0_rd_vld", 32'(rd_vld), 32'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("lat_n1_rd_vld", 32'(rd_vld), 32'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("lat_n2_rd_vld", 32'(rd_vld), 32'd1);
        checkOutput("lat_n2_rd_data", 32'(rd_data), 32'h1234);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // 2: fill to capacity, then one rejected write
        $display("[TB] fill to full");
        for (int i = 0; i < CAP; i++) begin
            applyStimulus(1'b1, DAW'(i), 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 16'hDEAD, 1'b0, 1'b0);
        checkOutput("full_head", 32'(rd_data), 32'd0);

        // 3: drain with rd_en held; first cycle also tries a write at full
        $display("[TB] drain full fifo");
        for (int i = 0; i < CAP; i++) begin
            checkOutput("stream_rd_vld", 32'(rd_vld), 32'd1);
            applyStimulus(i == 0, 16'hBEEF, 1'b1, 1'b0);
        end
        checkOutput("drained_rd_vld", 32'(rd_vld), 32'd0);
        checkOutput("drained_q", 32'(expq.size()), 32'd0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // 4: steady write+read at count 5 across pointer wrap
        $display("[TB] steady stream at count 5");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, DAW'(seq), 1'b0, 1'b0);
            seq++;
        end
        repeat (3) applyStimulus(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            checkOutput("steady_rd_vld", 32'(rd_vld), 32'd1);
            applyStimulus(1'b1, DAW'(seq), 1'b1, 1'b0);
            seq++;
        end

        // 5: flush at count 300 with wr_en and rd_en both high
        $display("[TB] flush");
        for (int i = 0; i < 295; i++) begin
            applyStimulus(1'b1, DAW'(seq), 1'b0, 1'b0);
            seq++;
        end
        checkOutput("pre_flush_count", 32'(count), 32'd300);
        applyStimulus(1'b1, 16'h5555, 1'b1, 1'b1);
        checkOutput("flush_rd_vld", 32'(rd_vld), 32'd0);
        repeat (3) applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("flush_nothing_stored", 32'(rd_vld), 32'd0);

        // 6: asynchronous reset mid-stream at count 7
        $display("[TB] reset mid-stream");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, DAW'(16'h0700 + i), 1'b0, 1'b0);
        end
        repeat (3) applyStimulus(1'b0, '0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checkState();
        checkOutput("async_rd_vld", 32'(rd_vld), 32'd0);
        checkOutput("async_rd_data", 32'(rd_data), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, DAW'(16'h00A0 + i), 1'b0, 1'b0);
        end
        repeat (3) applyStimulus(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("post_reset_rd_vld", 32'(rd_vld), 32'd1);
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
        end
        checkOutput("post_reset_q", 32'(expq.size()), 32'd0);
        checkOutput("post_reset_empty", 32'(rd_vld), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
